// File: rtl/memory_pkg.sv
// Shared memory-port definitions: word/address widths, size codes, response tag
// and the alignment rule applied to every granted request.
package memory_pkg;

    localparam int MEM_ADDR_WIDTH = 32;
    localparam int MEM_WORD_WIDTH = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    // Channel index field is sized for the largest supported arbiter (8 channels)
    localparam int TAG_IDX_W = 3;

    typedef struct packed {
        logic                 valid;
        logic [TAG_IDX_W-1:0] ch_idx;
        logic                 we;
        logic                 misalign;
    } mem_tag_t;

    function automatic logic is_misaligned(input logic [1:0] nbytes, input logic [1:0] addr_lsb);
        logic mis;
        case (nbytes)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = addr_lsb[0];
            SZ_WORD: mis = (addr_lsb != 2'b00);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_req_arbiter_rr_arbiter.sv
// Single-grant arbiter: round-robin from a rotating pointer, or fixed priority
// with channel 0 highest. Grant is combinational; only the pointer is state.
module rr_arbiter
    import memory_pkg::*;
#(
    parameter int N_CH     = 2,
    parameter int ARB_MODE = 0
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [N_CH-1:0]      req,
    output logic [N_CH-1:0]      gnt,
    output logic                 gnt_valid,
    output logic [TAG_IDX_W-1:0] gnt_idx
);

    localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [PW-1:0]   ptr_r;
    logic [PW-1:0]   ptr_nxt_s;
    logic [PW-1:0]   idx_s;
    logic [PW:0]     cand_s;
    logic [N_CH-1:0] gnt_s;
    logic            found_s;

    // Scan candidates starting at the pointer (or at 0 in fixed mode); first requester wins
    always_comb begin
        gnt_s   = '0;
        idx_s   = '0;
        found_s = 1'b0;
        cand_s  = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (ARB_MODE == 1) begin
                cand_s = (PW+1)'(i);
            end else begin
                cand_s = {1'b0, ptr_r} + (PW+1)'(i);
                if (cand_s >= (PW+1)'(N_CH)) begin
                    cand_s = cand_s - (PW+1)'(N_CH);
                end else begin
                    cand_s = cand_s;
                end
            end
            if (!found_s && req[cand_s[PW-1:0]]) begin
                found_s              = 1'b1;
                idx_s                = cand_s[PW-1:0];
                gnt_s[cand_s[PW-1:0]] = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Pointer moves just past the winner; it stays put on idle cycles and in fixed mode
    always_comb begin
        if (found_s && (ARB_MODE == 0)) begin
            if (idx_s == PW'(N_CH - 1)) begin
                ptr_nxt_s = '0;
            end else begin
                ptr_nxt_s = idx_s + PW'(1);
            end
        end else begin
            ptr_nxt_s = ptr_r;
        end
    end

    // Pointer register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ptr_r <= '0;
        end else begin
            ptr_r <= ptr_nxt_s;
        end
    end

    assign gnt       = gnt_s;
    assign gnt_valid = found_s;
    assign gnt_idx   = TAG_IDX_W'(idx_s);

endmodule

// File: rtl/mem_req_arbiter.sv
// N-channel requester arbiter onto one fixed-latency memory port. Misaligned
// grants are swallowed locally but still return an error response in order.
module mem_req_arbiter
    import memory_pkg::*;
#(
    parameter int N_CH       = 2,
    parameter int RD_LATENCY = 1,
    parameter int ARB_MODE   = 0,
    parameter int AW         = MEM_ADDR_WIDTH,
    parameter int DW         = MEM_WORD_WIDTH
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [N_CH-1:0]    ch_req_i,
    input  logic [N_CH-1:0]    ch_we_i,
    input  logic [2*N_CH-1:0]  ch_nbytes_i,
    input  logic [AW*N_CH-1:0] ch_addr_i,
    input  logic [DW*N_CH-1:0] ch_wdata_i,
    output logic [N_CH-1:0]    ch_gnt_o,
    output logic [N_CH-1:0]    ch_rvalid_o,
    output logic [DW-1:0]      ch_rdata_o,
    output logic               ch_err_o,
    output logic               mem_req_o,
    output logic               mem_we_o,
    output logic [1:0]         mem_nbytes_o,
    output logic [AW-1:0]      mem_addr_o,
    output logic [DW-1:0]      mem_wdata_o,
    input  logic [DW-1:0]      mem_rdata_i,
    input  logic               mem_addr_err_i
);

    logic [N_CH-1:0]      gnt_s;
    logic                 gnt_valid_s;
    logic [TAG_IDX_W-1:0] gnt_idx_s;
    logic                 sel_we_s;
    logic [1:0]           sel_nbytes_s;
    logic [AW-1:0]        sel_addr_s;
    logic [DW-1:0]        sel_wdata_s;
    logic                 misalign_s;
    logic                 issue_s;
    mem_tag_t             push_s;
    mem_tag_t             tail_s;
    mem_tag_t             tag_r [RD_LATENCY];
    logic [N_CH-1:0]      rvalid_nxt_s;
    logic                 err_nxt_s;
    logic [DW-1:0]        rdata_nxt_s;

    rr_arbiter #(
        .N_CH     (N_CH),
        .ARB_MODE (ARB_MODE)
    ) u_arb (
        .clk       (clk),
        .rstn      (rstn),
        .req       (ch_req_i),
        .gnt       (gnt_s),
        .gnt_valid (gnt_valid_s),
        .gnt_idx   (gnt_idx_s)
    );

    // AND-OR mux of the granted channel's fields (grant is one-hot)
    always_comb begin
        sel_we_s     = 1'b0;
        sel_nbytes_s = 2'b00;
        sel_addr_s   = '0;
        sel_wdata_s  = '0;
        for (int i = 0; i < N_CH; i++) begin
            sel_we_s     = sel_we_s     | (ch_we_i[i] & gnt_s[i]);
            sel_nbytes_s = sel_nbytes_s | (ch_nbytes_i[2*i +: 2] & {2{gnt_s[i]}});
            sel_addr_s   = sel_addr_s   | (ch_addr_i[AW*i +: AW] & {AW{gnt_s[i]}});
            sel_wdata_s  = sel_wdata_s  | (ch_wdata_i[DW*i +: DW] & {DW{gnt_s[i]}});
        end
    end

    assign misalign_s = gnt_valid_s & is_misaligned(sel_nbytes_s, sel_addr_s[1:0]);
    assign issue_s    = gnt_valid_s & ~misalign_s;

    assign ch_gnt_o     = gnt_s;
    assign mem_req_o    = issue_s;
    assign mem_we_o     = issue_s & sel_we_s;
    assign mem_nbytes_o = sel_nbytes_s & {2{issue_s}};
    assign mem_addr_o   = sel_addr_s & {AW{issue_s}};
    assign mem_wdata_o  = sel_wdata_s & {DW{issue_s}};

    // Every grant, aligned or not, enters the tag pipe so responses stay in order
    always_comb begin
        push_s.valid    = gnt_valid_s;
        push_s.ch_idx   = gnt_idx_s;
        push_s.we       = sel_we_s;
        push_s.misalign = misalign_s;
    end

    // Tag shift register, one stage per cycle of memory latency
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                tag_r[i] <= '0;
            end
        end else begin
            tag_r[0] <= push_s;
            for (int i = 1; i < RD_LATENCY; i++) begin
                tag_r[i] <= tag_r[i-1];
            end
        end
    end

    assign tail_s = tag_r[RD_LATENCY-1];

    // Tail lines up with the memory's data/error; build the response to register
    always_comb begin
        rvalid_nxt_s = '0;
        for (int i = 0; i < N_CH; i++) begin
            rvalid_nxt_s[i] = tail_s.valid & (tail_s.ch_idx == TAG_IDX_W'(i));
        end
        err_nxt_s = tail_s.valid & (tail_s.misalign | mem_addr_err_i);
        if (tail_s.valid && !tail_s.we && !err_nxt_s) begin
            rdata_nxt_s = mem_rdata_i;
        end else begin
            rdata_nxt_s = '0;
        end
    end

    // Registered response outputs
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ch_rvalid_o <= '0;
            ch_err_o    <= 1'b0;
            ch_rdata_o  <= '0;
        end else begin
            ch_rvalid_o <= rvalid_nxt_s;
            ch_err_o    <= err_nxt_s;
            ch_rdata_o  <= rdata_nxt_s;
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench: 3-channel, latency-2 arbiter in round-robin and fixed-priority
// builds sharing one stimulus set; expected values are hand-computed.
module tb_mem_req_arbiter;
    import memory_pkg::*;

    localparam int N  = 3;
    localparam int L  = 2;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [N-1:0]    ch_req;
    logic [N-1:0]    ch_we;
    logic [2*N-1:0]  ch_nbytes;
    logic [32*N-1:0] ch_addr;
    logic [32*N-1:0] ch_wdata;
    logic [31:0]     mem_rdata;
    logic            mem_addr_err;

    logic [N-1:0] rr_gnt, rr_rvalid, fp_gnt, fp_rvalid;
    logic [31:0]  rr_rdata, fp_rdata, rr_maddr, fp_maddr, rr_mwdata, fp_mwdata;
    logic         rr_err, fp_err, rr_mreq, fp_mreq, rr_mwe, fp_mwe;
    logic [1:0]   rr_mnb, fp_mnb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_req_arbiter #(.N_CH(N), .RD_LATENCY(L), .ARB_MODE(0)) dut_rr (
        .clk(clk), .rstn(rstn), .ch_req_i(ch_req), .ch_we_i(ch_we), .ch_nbytes_i(ch_nbytes),
        .ch_addr_i(ch_addr), .ch_wdata_i(ch_wdata), .ch_gnt_o(rr_gnt), .ch_rvalid_o(rr_rvalid),
        .ch_rdata_o(rr_rdata), .ch_err_o(rr_err), .mem_req_o(rr_mreq), .mem_we_o(rr_mwe),
        .mem_nbytes_o(rr_mnb), .mem_addr_o(rr_maddr), .mem_wdata_o(rr_mwdata),
        .mem_rdata_i(mem_rdata), .mem_addr_err_i(mem_addr_err));

    mem_req_arbiter #(.N_CH(N), .RD_LATENCY(L), .ARB_MODE(1)) dut_fp (
        .clk(clk), .rstn(rstn), .ch_req_i(ch_req), .ch_we_i(ch_we), .ch_nbytes_i(ch_nbytes),
        .ch_addr_i(ch_addr), .ch_wdata_i(ch_wdata), .ch_gnt_o(fp_gnt), .ch_rvalid_o(fp_rvalid),
        .ch_rdata_o(fp_rdata), .ch_err_o(fp_err), .mem_req_o(fp_mreq), .mem_we_o(fp_mwe),
        .mem_nbytes_o(fp_mnb), .mem_addr_o(fp_maddr), .mem_wdata_o(fp_mwdata),
        .mem_rdata_i(mem_rdata), .mem_addr_err_i(mem_addr_err));

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic clear_inputs();
        ch_req = '0; ch_we = '0; ch_nbytes = '0; ch_addr = '0; ch_wdata = '0;
    endtask

    task automatic set_ch(input int ch, input logic we, input logic [1:0] nb,
                          input logic [31:0] addr, input logic [31:0] wd);
        ch_req[ch]            = 1'b1;
        ch_we[ch]             = we;
        ch_nbytes[2*ch +: 2]  = nb;
        ch_addr[32*ch +: 32]  = addr;
        ch_wdata[32*ch +: 32] = wd;
    endtask

    task automatic test_reset();
        logic [115:0] rr_all, fp_all;
        clear_inputs();
        mem_rdata = 32'h0; mem_addr_err = 1'b0;
        rstn = 1'b0;
        repeat (3) next_cycle();
        rstn = 1'b1;
        for (int c = 0; c < 10; c++) begin
            settle();
            rr_all = {rr_gnt, rr_rvalid, rr_rdata, rr_err, rr_mreq, rr_mwe, rr_mnb, rr_maddr, rr_mwdata[31:7]};
            fp_all = {fp_gnt, fp_rvalid, fp_rdata, fp_err, fp_mreq, fp_mwe, fp_mnb, fp_maddr, fp_mwdata[31:7]};
            checks++;
            if (rr_all !== 116'h0 || rr_mwdata !== 32'h0) begin
                errors++; $display("FAIL reset_idle_rr c%0d: got %h expected 0", c, rr_all);
            end
            checks++;
            if (fp_all !== 116'h0 || fp_mwdata !== 32'h0) begin
                errors++; $display("FAIL reset_idle_fp c%0d: got %h expected 0", c, fp_all);
            end
            next_cycle();
        end
        // two reads in flight, then reset before they return
        set_ch(0, 1'b0, SZ_WORD, 32'h40, 32'h0);
        next_cycle();
        set_ch(0, 1'b0, SZ_WORD, 32'h44, 32'h0);
        next_cycle();
        clear_inputs();
        mem_rdata = 32'h1111_1111;
        rstn = 1'b0;
        next_cycle();
        rstn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            settle();
            checks++;
            if (rr_rvalid !== 3'b000) begin
                errors++; $display("FAIL reset_flush c%0d: got %b expected 000", c, rr_rvalid);
            end
            next_cycle();
        end
        mem_rdata = 32'h0;
    endtask

    task automatic test_read_latency();
        set_ch(0, 1'b0, SZ_WORD, 32'h10, 32'h0);
        settle();
        checks++;
        if ({rr_gnt, rr_mreq, rr_mwe, rr_mnb} !== {3'b001, 1'b1, 1'b0, SZ_WORD}) begin
            errors++; $display("FAIL rd_issue: got gnt=%b req=%b we=%b nb=%b expected 001 1 0 10",
                               rr_gnt, rr_mreq, rr_mwe, rr_mnb);
        end
        checks++;
        if (rr_maddr !== 32'h10) begin
            errors++; $display("FAIL rd_addr: got %h expected 00000010", rr_maddr);
        end
        next_cycle();
        clear_inputs();
        settle();
        checks++;
        if (rr_rvalid !== 3'b000) begin
            errors++; $display("FAIL rd_early1: got %b expected 000", rr_rvalid);
        end
        next_cycle();
        mem_rdata = 32'hDEAD_BEEF;
        settle();
        checks++;
        if (rr_rvalid !== 3'b000) begin
            errors++; $display("FAIL rd_early2: got %b expected 000", rr_rvalid);
        end
        next_cycle();
        mem_rdata = 32'h0;
        settle();
        checks++;
        if ({rr_rvalid, rr_err, rr_rdata} !== {3'b001, 1'b0, 32'hDEAD_BEEF}) begin
            errors++; $display("FAIL rd_resp: got rv=%b err=%b data=%h expected 001 0 deadbeef",
                               rr_rvalid, rr_err, rr_rdata);
        end
        next_cycle();
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_v;
        clear_inputs();
        rstn = 1'b0;
        next_cycle();
        rstn = 1'b1;
        mem_rdata = 32'h1357_9BDF; mem_addr_err = 1'b0;
        for (int c = 0; c < 9; c++) begin
            clear_inputs();
            if (c < 6) begin
                for (int k = 0; k < N; k++) set_ch(k, 1'b0, SZ_WORD, 32'(4 * k), 32'h0);
            end
            settle();
            if (c < 6) begin
                exp_v = 3'b001 << (c % 3);
                checks++;
                if (rr_gnt !== exp_v) begin
                    errors++; $display("FAIL rr_gnt c%0d: got %b expected %b", c, rr_gnt, exp_v);
                end
                checks++;
                if (rr_maddr !== 32'(4 * (c % 3))) begin
                    errors++; $display("FAIL rr_addr c%0d: got %h expected %h", c, rr_maddr, 4 * (c % 3));
                end
            end
            if (c < 3) begin
                checks++;
                if (rr_rvalid !== 3'b000) begin
                    errors++; $display("FAIL rr_rv_early c%0d: got %b expected 000", c, rr_rvalid);
                end
            end else begin
                exp_v = 3'b001 << ((c - 3) % 3);
                checks++;
                if ({rr_rvalid, rr_rdata} !== {exp_v, 32'h1357_9BDF}) begin
                    errors++; $display("FAIL rr_resp c%0d: got rv=%b data=%h expected %b 13579bdf",
                                       c, rr_rvalid, rr_rdata, exp_v);
                end
            end
            next_cycle();
        end
        mem_rdata = 32'h0;
    endtask

    task automatic test_fixed_priority();
        logic [N-1:0] exp_v;
        mem_rdata = 32'h2468_ACE0; mem_addr_err = 1'b0;
        for (int c = 0; c < 8; c++) begin
            clear_inputs();
            if (c < 4) set_ch(0, 1'b0, SZ_WORD, 32'h100, 32'h0);
            if (c < 5) set_ch(2, 1'b0, SZ_WORD, 32'h200, 32'h0);
            settle();
            exp_v = (c < 4) ? 3'b001 : ((c == 4) ? 3'b100 : 3'b000);
            checks++;
            if (fp_gnt !== exp_v) begin
                errors++; $display("FAIL fp_gnt c%0d: got %b expected %b", c, fp_gnt, exp_v);
            end
            if (c == 1) begin
                // round-robin build rotates to ch2 where fixed priority keeps ch0
                checks++;
                if (rr_gnt !== 3'b100) begin
                    errors++; $display("FAIL rr_vs_fp c1: got %b expected 100", rr_gnt);
                end
            end
            exp_v = (c < 3) ? 3'b000 : ((c < 7) ? 3'b001 : 3'b100);
            checks++;
            if (fp_rvalid !== exp_v) begin
                errors++; $display("FAIL fp_resp c%0d: got %b expected %b", c, fp_rvalid, exp_v);
            end
            if (c == 7) begin
                checks++;
                if (fp_rdata !== 32'h2468_ACE0) begin
                    errors++; $display("FAIL fp_rdata: got %h expected 2468ace0", fp_rdata);
                end
            end
            next_cycle();
        end
        mem_rdata = 32'h0;
    endtask

    task automatic test_misaligned();
        logic [1:0]  nb_tab  [4] = '{SZ_WORD, SZ_RSVD, SZ_HALF, SZ_BYTE};
        logic [31:0] adr_tab [4] = '{32'h2, 32'h0, 32'h1, 32'h3};
        logic        mis_tab [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] exp_d;
        mem_addr_err = 1'b0;
        for (int t = 0; t < 4; t++) begin
            clear_inputs();
            set_ch(1, 1'b0, nb_tab[t], adr_tab[t], 32'h0);
            mem_rdata = 32'hFFFF_FFFF;
            settle();
            checks++;
            if ({rr_gnt, rr_mreq} !== {3'b010, ~mis_tab[t]}) begin
                errors++; $display("FAIL mis_issue t%0d: got gnt=%b req=%b expected 010 %b",
                                   t, rr_gnt, rr_mreq, ~mis_tab[t]);
            end
            next_cycle();
            clear_inputs();
            repeat (2) next_cycle();
            settle();
            exp_d = mis_tab[t] ? 32'h0 : 32'hFFFF_FFFF;
            checks++;
            if ({rr_rvalid, rr_err, rr_rdata} !== {3'b010, mis_tab[t], exp_d}) begin
                errors++; $display("FAIL mis_resp t%0d: got rv=%b err=%b data=%h expected 010 %b %h",
                                   t, rr_rvalid, rr_err, rr_rdata, mis_tab[t], exp_d);
            end
            next_cycle();
        end
        mem_rdata = 32'h0;
    endtask

    task automatic test_write_ack();
        logic aerr_tab [2] = '{1'b1, 1'b0};
        for (int t = 0; t < 2; t++) begin
            clear_inputs();
            set_ch(0, 1'b1, SZ_WORD, 32'h20, 32'hCAFE_F00D);
            mem_addr_err = 1'b0;
            mem_rdata = 32'hFFFF_FFFF;
            settle();
            checks++;
            if ({rr_gnt, rr_mreq, rr_mwe, rr_mwdata} !== {3'b001, 1'b1, 1'b1, 32'hCAFE_F00D}) begin
                errors++; $display("FAIL wr_issue t%0d: got gnt=%b req=%b we=%b wd=%h expected 001 1 1 cafef00d",
                                   t, rr_gnt, rr_mreq, rr_mwe, rr_mwdata);
            end
            next_cycle();
            clear_inputs();
            next_cycle();
            mem_addr_err = aerr_tab[t];
            next_cycle();
            mem_addr_err = 1'b0;
            settle();
            checks++;
            if ({rr_rvalid, rr_err, rr_rdata} !== {3'b001, aerr_tab[t], 32'h0}) begin
                errors++; $display("FAIL wr_ack t%0d: got rv=%b err=%b data=%h expected 001 %b 00000000",
                                   t, rr_rvalid, rr_err, rr_rdata, aerr_tab[t]);
            end
            next_cycle();
        end
        mem_rdata = 32'h0;
    endtask

    initial begin
        clear_inputs();
        mem_rdata = 32'h0;
        mem_addr_err = 1'b0;
        test_reset();
        test_read_latency();
        test_round_robin();
        test_fixed_priority();
        test_misaligned();
        test_write_ack();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Parametrised N-channel arbiter that multiplexes core-side memory requesters onto one read/write memory port. Typical requesters are instruction fetch, load/store and debug/DMA.
- Memory port signal set is REQ/WRITE_EN/N_BYTES/ADDR/W_DATA/R_DATA/ADDR_ERR, as in the existing mem_read_write interface.
- Adds over the plain interface: grant handshake, round-robin or fixed-priority arbitration, pipelined fixed-latency responses routed back by channel tag, and alignment checking.
- Sits between core pipeline stages and the unified memory model.

Parameters:
- N_CH, 2: number of requester channels (1..8).
- RD_LATENCY, 1: cycles from mem_req_o to valid mem_rdata_i / mem_addr_err_i (1..4).
- ARB_MODE, 0: 0 = round-robin; 1 = fixed priority, channel 0 highest.
- AW, MEM_ADDR_WIDTH: address width, from memory_pkg.
- DW, MEM_WORD_WIDTH: data width, from memory_pkg; must be 32.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rstn  in  1  synchronous active-low reset.
- ch_req_i  in  N_CH  per-channel request, level.
- ch_we_i  in  N_CH  1 = write.
- ch_nbytes_i  in  2*N_CH  size code: 00 = byte, 01 = half, 10 = word, 11 = reserved.
- ch_addr_i  in  AW*N_CH  byte address.
- ch_wdata_i  in  DW*N_CH  write data.
- ch_gnt_o  out  N_CH  one-hot grant; request accepted this cycle.
- ch_rvalid_o  out  N_CH  one-hot response valid.
- ch_rdata_o  out  DW  read data; 0 for writes and errors.
- ch_err_o  out  1  response error, qualified by ch_rvalid_o.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  memory write enable.
- mem_nbytes_o  out  2  memory size code.
- mem_addr_o  out  AW  memory address.
- mem_wdata_o  out  DW  memory write data.
- mem_rdata_i  in  DW  memory read data.
- mem_addr_err_i  in  1  memory address error.

Behaviour:
- Clocking: one clock clk; reset rstn is synchronous, active-low. While rstn=0 at a clock edge:
  - all registered outputs are cleared to 0;
  - the RR pointer is set to 0;
  - the tag pipeline is cleared, so in-flight responses are discarded and never delivered.
- Arbitration (combinational, same cycle):
  - At most one ch_gnt_o bit is high, and only for a channel with ch_req_i=1.
  - The memory port is always ready: any pending request yields a grant every cycle.
  - A requester holds req/we/nbytes/addr/wdata stable until it sees gnt; it drops req, or presents the next request, the cycle after gnt.
  - ARB_MODE=0: search starts at the RR pointer. Pointer becomes granted index + 1 (mod N_CH) on each grant and is unchanged when there is no grant.
  - ARB_MODE=1: lowest requesting index wins; starvation is allowed.
- Alignment check on the granted request; it is misaligned if any of these hold:
  - nbytes=11;
  - nbytes=01 with addr[0]=1;
  - nbytes=10 with addr[1:0]≠00.
- Issue:
  - Aligned grant: mem_* outputs carry the granted channel's fields combinationally, with mem_req_o=1 in the grant cycle.
  - Misaligned grant: mem_req_o=0 (memory never sees it).
  - No grant: mem_req_o=0 and the other mem_* outputs are 0.
- Tag pipeline:
  - Shift register of depth RD_LATENCY; each entry is {valid, ch_idx, we, misalign}.
  - Every grant, aligned or not, pushes one entry at the grant edge.
  - At most RD_LATENCY requests are outstanding, fully pipelined; back-to-back grants are permitted every cycle.
- Response (registered):
  - When the pipeline tail is valid at cycle G+RD_LATENCY (G = grant cycle), the next edge registers the outputs. The response is therefore visible in cycle G+RD_LATENCY+1.
  - ch_rvalid_o = one-hot of ch_idx.
  - ch_err_o = misalign | (~misalign & mem_addr_err_i).
  - ch_rdata_o = mem_rdata_i only for a read with err=0; otherwise 0.
  - Otherwise ch_rvalid_o=0, ch_err_o=0, ch_rdata_o=0.
- Writes return an ack response: rvalid with rdata=0; err reflects misalign or mem_addr_err_i.
- Responses are returned in grant order, exactly one per grant.
- N_CH=1 degenerates to a pass-through with registered response; gnt = req.

Decomposition:
- memory_pkg gains:
  - size-code constants SZ_BYTE, SZ_HALF, SZ_WORD;
  - the mem_tag_t struct {valid, ch_idx[$clog2(N_CH) max 3 bits], we, misalign};
  - a function is_misaligned(nbytes, addr[1:0]).
- One sub-module: rr_arbiter, carrying the N_CH request vector, ARB_MODE, the one-hot grant and the pointer register.

Test Plan:
- Reset then idle: all outputs 0 and no rvalid for 10 cycles. Assert rstn=0 with 2 reads in flight → no rvalid after release.
- RD_LATENCY=2, ch0 word read at addr 0x10 in cycle 5, memory returns 0xDEADBEEF → mem_req_o=1 in cycle 5; ch_rvalid_o=01, ch_rdata_o=0xDEADBEEF, err=0 in cycle 8.
- ARB_MODE=0, N_CH=3, all channels requesting continuously → grants 001,010,100,001… one per cycle; responses in the same order, back-to-back.
- ARB_MODE=1, ch0 and ch2 requesting for 4 cycles → ch0 granted all 4 cycles; ch2 granted in cycle 5 after ch0 drops.
- Misaligned: ch1 word read at addr 0x2, and a separate request with nbytes=11 → mem_req_o=0 for each; rvalid=10, err=1, rdata=0 after RD_LATENCY+1.
- ch0 write with memory raising mem_addr_err_i=1 at the response cycle → rvalid=01, err=1, rdata=0. The same write with mem_addr_err_i=0 → err=0.
